mc_array_seq: RTL and testbench

Timing sequencer that sits directly upstream of the 64x64 memristor compute array and drives its pins. It turns word-level read/write requests, given as a row index plus 64-bit data, into the multi-phase pin sequences the array cells require: two-phase complementary program, then precharge, arm and evaluate for read. It captures the array's DOUT bus and returns it as a registered response.

---
 rtl/mc_seq_pkg.sv | 29 ++
 rtl/mc_row_decoder.sv | 26 ++
 rtl/mc_array_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_mc_array_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_seq_pkg.sv
// Shared types and constants for the memristor array sequencer.
// Column commands are encoded as {CBL, CSL} for the cell being programmed.
package mc_seq_pkg;

    localparam int MC_ROWS = 64;
    localparam int MC_COLS = 64;

    localparam logic [1:0] MC_CMD_M1_CLR = 2'b00;
    localparam logic [1:0] MC_CMD_M0_SET = 2'b01;
    localparam logic [1:0] MC_CMD_M0_CLR = 2'b10;
    localparam logic [1:0] MC_CMD_M1_SET = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_GAP,
        ST_WR_B,
        ST_PRE,
        ST_ARM,
        ST_EVAL,
        ST_RESP
    } mc_seq_state_e;

    // Phases in which the latched row's word line is raised.
    function automatic logic names_row(mc_seq_state_e st);
        return (st == ST_WR_A) || (st == ST_WR_B) || (st == ST_ARM) || (st == ST_EVAL);
    endfunction

endpackage

// File: rtl/mc_row_decoder.sv
// Combinational row decoder: even rows map to wlo[r/2], odd rows to wle[r/2].
// At most one line is high, and only while en is set.
module mc_row_decoder #(
    parameter int ROWS = 64
) (
    input  logic [$clog2(ROWS)-1:0] row,
    input  logic                    en,
    output logic [ROWS/2-1:0]       wle,
    output logic [ROWS/2-1:0]       wlo
);

    localparam int RW = $clog2(ROWS);

    always_comb begin
        wle = '0;
        wlo = '0;
        if (en) begin
            if (row[0]) begin
                wle[row[RW-1:1]] = 1'b1;
            end else begin
                wlo[row[RW-1:1]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_array_seq.sv
// Pin sequencer for the 64x64 memristor array: program (two-phase) and read (precharge/arm/eval).
// Define MC_SEQ_VERIFY_EN to follow every write with a readback and mismatch flag.
module mc_array_seq
    import mc_seq_pkg::*;
#(
    parameter int ROWS         = MC_ROWS,
    parameter int COLS         = MC_COLS,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [$clog2(ROWS)-1:0] req_row_i,
    input  logic [COLS-1:0]         req_wdata_i,
    input  logic [COLS-1:0]         req_wmask_i,
    output logic                    rsp_valid_o,
    output logic [COLS-1:0]         rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    busy_o,
    output logic [ROWS/2-1:0]       CWLE_o,
    output logic [ROWS/2-1:0]       CWLO_o,
    output logic [COLS-1:0]         CBLEN_o,
    output logic [COLS-1:0]         CBL_o,
    output logic [COLS-1:0]         CSL_o,
    output logic [COLS-1:0]         DIN_o,
    output logic [COLS-1:0]         DINb_o,
    input  logic [COLS-1:0]         DOUT_i
);

    localparam int         RW       = $clog2(ROWS);
    localparam logic [3:0] CNT_LOAD = 4'(PULSE_CYCLES - 1);

    mc_seq_state_e     state_q;
    mc_seq_state_e     state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic [RW-1:0]     row_q;
    logic [COLS-1:0]   wdata_q;
    logic [COLS-1:0]   wmask_q;

    logic              accept;
    logic [RW-1:0]     sel_row;
    logic [COLS-1:0]   sel_wdata;
    logic [COLS-1:0]   sel_wmask;

    logic              wl_en;
    logic [ROWS/2-1:0] wle_d;
    logic [ROWS/2-1:0] wlo_d;
    logic [COLS-1:0]   cblen_d;
    logic [COLS-1:0]   cbl_d;
    logic [COLS-1:0]   csl_d;
    logic [COLS-1:0]   din_d;
    logic [COLS-1:0]   dinb_d;
    logic [COLS-1:0]   rdata_d;

`ifdef MC_SEQ_VERIFY_EN
    logic              we_q;
    logic              err_d;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign accept = req_valid_i && req_ready_o;

    // The first phase is registered on the accept edge, so it must see the live request.
    assign sel_row   = accept ? req_row_i   : row_q;
    assign sel_wdata = accept ? req_wdata_i : wdata_q;
    assign sel_wmask = accept ? req_wmask_i : wmask_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = req_we_i ? ST_WR_A : ST_PRE;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WR_A: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_WR_GAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WR_GAP: begin
                state_d = ST_WR_B;
                cnt_d   = CNT_LOAD;
            end
            ST_WR_B: begin
                if (cnt_q == 4'd0) begin
`ifdef MC_SEQ_VERIFY_EN
                    state_d = ST_PRE;
                    cnt_d   = CNT_LOAD;
`else
                    state_d = ST_RESP;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_PRE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ARM;
                    cnt_d   = CNT_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ARM: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_EVAL;
                    cnt_d   = CNT_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_EVAL: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wl_en = names_row(state_d);

    mc_row_decoder #(
        .ROWS (ROWS)
    ) u_row_decoder (
        .row (sel_row),
        .en  (wl_en),
        .wle (wle_d),
        .wlo (wlo_d)
    );

    // Column drives for the phase being entered; registered below so the pins never glitch.
    always_comb begin
        cblen_d = '0;
        cbl_d   = '0;
        csl_d   = '0;
        din_d   = '0;
        dinb_d  = '0;
        case (state_d)
            ST_WR_A: begin
                cblen_d = sel_wmask;
                for (int c = 0; c < COLS; c++) begin
                    {cbl_d[c], csl_d[c]} = sel_wdata[c] ? MC_CMD_M0_SET : MC_CMD_M0_CLR;
                end
            end
            ST_WR_B: begin
                cblen_d = sel_wmask;
                for (int c = 0; c < COLS; c++) begin
                    {cbl_d[c], csl_d[c]} = sel_wdata[c] ? MC_CMD_M1_CLR : MC_CMD_M1_SET;
                end
            end
            ST_PRE, ST_ARM: begin
                csl_d = '1;
            end
            ST_EVAL: begin
                din_d = '1;
            end
            default: begin
                cblen_d = '0;
            end
        endcase
    end

    // Cells output ~m0 during evaluation, so the stored word is the inverted bus.
    always_comb begin
        rdata_d = '0;
`ifdef MC_SEQ_VERIFY_EN
        err_d   = 1'b0;
`endif
        if (state_q == ST_EVAL && state_d == ST_RESP) begin
            rdata_d = ~DOUT_i;
`ifdef MC_SEQ_VERIFY_EN
            err_d   = we_q && |((~DOUT_i ^ wdata_q) & wmask_q);
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            CWLE_o      <= '0;
            CWLO_o      <= '0;
            CBLEN_o     <= '0;
            CBL_o       <= '0;
            CSL_o       <= '0;
            DIN_o       <= '0;
            DINb_o      <= '0;
`ifdef MC_SEQ_VERIFY_EN
            we_q        <= 1'b0;
            rsp_err_o   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (accept) begin
                row_q   <= req_row_i;
                wdata_q <= req_wdata_i;
                wmask_q <= req_wmask_i;
`ifdef MC_SEQ_VERIFY_EN
                we_q    <= req_we_i;
`endif
            end
            req_ready_o <= (state_d == ST_IDLE);
            busy_o      <= (state_d != ST_IDLE);
            rsp_valid_o <= (state_d == ST_RESP);
            rsp_rdata_o <= rdata_d;
            CWLE_o      <= wle_d;
            CWLO_o      <= wlo_d;
            CBLEN_o     <= cblen_d;
            CBL_o       <= cbl_d;
            CSL_o       <= csl_d;
            DIN_o       <= din_d;
            DINb_o      <= dinb_d;
`ifdef MC_SEQ_VERIFY_EN
            rsp_err_o   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mc_array_seq.sv
// Bench for mc_array_seq: pin-level array model plus a word-level memory reference.
// Honours MC_SEQ_VERIFY_EN for write latency, readback and the forced-mismatch case.
module tb_mc_array_seq;

    localparam int P = 2;
`ifdef MC_SEQ_VERIFY_EN
    localparam bit VERIFY = 1'b1;
    localparam int WR_LAT = 5 * P + 2;
`else
    localparam bit VERIFY = 1'b0;
    localparam int WR_LAT = 2 * P + 2;
`endif
    localparam int RD_LAT = 3 * P + 1;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [5:0]  req_row;
    logic [63:0] req_wdata;
    logic [63:0] req_wmask;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] CWLE_o, CWLO_o;
    logic [63:0] CBLEN_o, CBL_o, CSL_o, DIN_o, DINb_o, DOUT_i;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] cell_m0 [64] = '{default: 64'h0};
    logic [63:0] cell_m1 [64] = '{default: 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] mem_ref [64] = '{default: 64'h0};
    logic        flip_bit3 = 1'b0;
    int          wl_cnt;
    int          act_row;
    logic [383:0] array_outs;

    always #5 clk_i = ~clk_i;

    mc_array_seq #(.ROWS(64), .COLS(64), .PULSE_CYCLES(P)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_row_i   (req_row),
        .req_wdata_i (req_wdata),
        .req_wmask_i (req_wmask),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .CWLE_o      (CWLE_o),
        .CWLO_o      (CWLO_o),
        .CBLEN_o     (CBLEN_o),
        .CBL_o       (CBL_o),
        .CSL_o       (CSL_o),
        .DIN_o       (DIN_o),
        .DINb_o      (DINb_o),
        .DOUT_i      (DOUT_i)
    );

    assign array_outs = {CWLE_o, CWLO_o, CBLEN_o, CBL_o, CSL_o, DIN_o, DINb_o};

    // Array model: which row is selected, and what the cells put on DOUT while evaluated.
    always_comb begin
        wl_cnt  = $countones({CWLE_o, CWLO_o});
        act_row = 0;
        for (int i = 0; i < 32; i++) begin
            if (CWLO_o[i]) act_row = 2 * i;
            if (CWLE_o[i]) act_row = 2 * i + 1;
        end
        DOUT_i = '0;
        if (wl_cnt == 1 && (&DIN_o) && DINb_o == '0 && CSL_o == '0) begin
            for (int c = 0; c < 64; c++) begin
                DOUT_i[c] = (cell_m0[act_row][c] == cell_m1[act_row][c]) ? 1'bx : ~cell_m0[act_row][c];
            end
            if (flip_bit3) DOUT_i[3] = ~DOUT_i[3];
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni && wl_cnt == 1) begin
            for (int c = 0; c < 64; c++) begin
                if (CBLEN_o[c]) begin
                    case ({CBL_o[c], CSL_o[c]})
                        2'b01: cell_m0[act_row][c] <= 1'b1;
                        2'b10: cell_m0[act_row][c] <= 1'b0;
                        2'b00: cell_m1[act_row][c] <= 1'b0;
                        default: cell_m1[act_row][c] <= 1'b1;
                    endcase
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for ready at a falling edge, presents the request and lets it be accepted.
    task automatic applyStimulus(input logic we, input logic [5:0] row, input logic [63:0] wdata,
                                 input logic [63:0] wmask);
        for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk_i);
        if (!req_ready) checkOutput("ready_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_row   = row;
        req_wdata = wdata;
        req_wmask = wmask;
        @(posedge clk_i);
    endtask

    // Called right after an accept edge; k counts cycles after the accept.
    task automatic waitResponse(output int lat, output logic [63:0] rdata, output logic err,
                                output int rdy_hi, output logic [63:0] wl_seen, output int max_wl);
        lat = -1; rdata = '0; err = 1'b0; rdy_hi = 0; wl_seen = '0; max_wl = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                req_valid = 1'b0;
                req_we    = 1'($urandom);
                req_row   = 6'($urandom);
                req_wdata = {$urandom, $urandom};
                req_wmask = {$urandom, $urandom};
            end
            if (req_ready) rdy_hi++;
            wl_seen |= {CWLE_o, CWLO_o};
            if (wl_cnt > max_wl) max_wl = wl_cnt;
            if (rsp_valid) begin
                lat   = k;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
        end
    endtask

    task automatic doOp(input string tag, input logic we, input logic [5:0] row,
                        input logic [63:0] wdata, input logic [63:0] wmask, input logic flip);
        logic [63:0] exp_data, rdata, wl_seen, wl_exp;
        logic        exp_err, err;
        int          lat, rdy, max_wl;
        if (we) mem_ref[row] = (mem_ref[row] & ~wmask) | (wdata & wmask);
        if (!we)         exp_data = mem_ref[row];
        else if (VERIFY) exp_data = mem_ref[row] ^ (flip ? 64'h8 : 64'h0);
        else             exp_data = 64'h0;
        exp_err = VERIFY && we && flip && wmask[3];
        wl_exp  = row[0] ? (64'd1 << (32 + int'(row[5:1]))) : (64'd1 << int'(row[5:1]));
        flip_bit3 = flip;
        applyStimulus(we, row, wdata, wmask);
        waitResponse(lat, rdata, err, rdy, wl_seen, max_wl);
        flip_bit3 = 1'b0;
        checkOutput({tag, "_latency"}, 64'(lat), 64'(we ? WR_LAT : RD_LAT));
        checkOutput({tag, "_rdata"}, rdata, exp_data);
        checkOutput({tag, "_err"}, 64'(err), 64'(exp_err));
        checkOutput({tag, "_ready_low"}, 64'(rdy), 64'd0);
        checkOutput({tag, "_wordline"}, wl_seen, wl_exp);
        checkOutput({tag, "_one_wl"}, 64'(max_wl), 64'd1);
    endtask

    initial begin
        int          lat, rdy, max_wl, k_rsp, k_ready, ready_low, rsp_seen;
        logic [63:0] rdata, wl_seen, bb_data;
        logic        err;
        logic [5:0]  row;

        rst_ni = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_row = '0; req_wdata = '0; req_wmask = '0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_rsp", {62'd0, rsp_valid, rsp_err}, 64'd0);
        checkOutput("rst_array_outs", 64'($countones(array_outs)), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("idle_ready", 64'(req_ready), 64'd1);
        checkOutput("idle_array_outs", 64'($countones(array_outs)), 64'd0);

        $display("[TB] write/read row 5 and word-line map");
        doOp("wr5", 1'b1, 6'd5, 64'hA5A5_0000_FFFF_1234, '1, 1'b0);
        doOp("rd5", 1'b0, 6'd5, 64'h0, 64'h0, 1'b0);
        checkOutput("rd5_const", mem_ref[5], 64'hA5A5_0000_FFFF_1234);
        doOp("rd0", 1'b0, 6'd0, 64'h0, 64'h0, 1'b0);
        doOp("rd1", 1'b0, 6'd1, 64'h0, 64'h0, 1'b0);
        doOp("wr63", 1'b1, 6'd63, {$urandom, $urandom}, '1, 1'b0);
        doOp("rd63", 1'b0, 6'd63, 64'h0, 64'h0, 1'b0);

        $display("[TB] partial and empty masks");
        doOp("wr2_ones", 1'b1, 6'd2, '1, '1, 1'b0);
        doOp("wr2_part", 1'b1, 6'd2, 64'h0, 64'h0000_0000_0000_00FF, 1'b0);
        doOp("rd2", 1'b0, 6'd2, 64'h0, 64'h0, 1'b0);
        checkOutput("rd2_const", mem_ref[2], 64'hFFFF_FFFF_FFFF_FF00);
        doOp("wr5_nomask", 1'b1, 6'd5, {$urandom, $urandom}, 64'h0, 1'b0);
        doOp("rd5_nomask", 1'b0, 6'd5, 64'h0, 64'h0, 1'b0);

        $display("[TB] back-to-back with valid held high");
        for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk_i);
        bb_data = {$urandom, $urandom};
        mem_ref[9] = bb_data;
        req_valid = 1'b1; req_we = 1'b1; req_row = 6'd9; req_wdata = bb_data; req_wmask = '1;
        @(posedge clk_i);
        k_rsp = -1; k_ready = -1; ready_low = 0; rdata = '1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                req_we = 1'b0; req_wdata = ~bb_data; req_wmask = {$urandom, $urandom};
            end
            if (rsp_valid) begin k_rsp = k; rdata = rsp_rdata; end
            if (req_ready) begin k_ready = k; break; end
            ready_low++;
        end
        checkOutput("bb_wr_latency", 64'(k_rsp), 64'(WR_LAT));
        checkOutput("bb_wr_rdata", rdata, VERIFY ? bb_data : 64'h0);
        checkOutput("bb_second_accept", 64'(k_ready), 64'(WR_LAT + 1));
        checkOutput("bb_ready_low_cycles", 64'(ready_low), 64'(WR_LAT));
        @(posedge clk_i);
        waitResponse(lat, rdata, err, rdy, wl_seen, max_wl);
        checkOutput("bb_rd_latency", 64'(lat), 64'(RD_LAT));
        checkOutput("bb_rd_rdata", rdata, bb_data);

        $display("[TB] reset during WR_B");
        applyStimulus(1'b1, 6'd40, {$urandom, $urandom}, '1);
        for (int k = 1; k <= P + 2; k++) begin
            @(negedge clk_i);
            if (k == 1) req_valid = 1'b0;
        end
        checkOutput("midwr_wl_active", 64'(wl_cnt), 64'd1);
        rst_ni = 1'b0;
        #1;
        checkOutput("midwr_array_outs", 64'($countones(array_outs)), 64'd0);
        checkOutput("midwr_busy", 64'(busy), 64'd0);
        checkOutput("midwr_ready", 64'(req_ready), 64'd1);
        rsp_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            if (rsp_valid) rsp_seen++;
        end
        rst_ni = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (rsp_valid) rsp_seen++;
        end
        checkOutput("midwr_no_rsp", 64'(rsp_seen), 64'd0);
        checkOutput("midwr_ready_after", 64'(req_ready), 64'd1);

`ifdef MC_SEQ_VERIFY_EN
        $display("[TB] verify readback with forced DOUT[3] flip");
        doOp("vfy_flip", 1'b1, 6'd11, {$urandom, $urandom}, '1, 1'b1);
        doOp("vfy_clean", 1'b1, 6'd11, {$urandom, $urandom}, '1, 1'b0);
`endif

        $display("[TB] randomized traffic");
        for (int n = 0; n < 16; n++) begin
            row = 6'($urandom_range(0, 63));
            if (row == 6'd40) row = 6'd41;
            doOp($sformatf("rand%0d", n), 1'($urandom), row, {$urandom, $urandom},
                 (n % 5 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom}, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
